// File: rtl/motor3_six_step_seq_pkg.sv
// Shared constants, FSM state type and step-table helpers for the three-phase
// six-step commutation sequencer.
package motor3_pkg;

  localparam logic [1:0] CODE_OFF  = 2'd0;
  localparam logic [1:0] CODE_LOW  = 2'd1;
  localparam logic [1:0] CODE_HIGH = 2'd2;

  localparam int unsigned STEP_THRESH = 166667;
  localparam int unsigned DEAD_CYC    = 2;
  localparam int unsigned PWM_PERIOD  = 15;

  localparam int unsigned FREQ_MIN  = 1;
  localparam int unsigned FREQ_MAX  = 1000;
  localparam int unsigned FREQ_RST  = 100;
  localparam int unsigned POWER_MAX = 15;

  localparam int ACC_W   = 20;
  localparam int FREQ_W  = 10;
  localparam int POWER_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEAD  = 2'd2,
    ST_BRAKE = 2'd3
  } motor3_state_e;

  function automatic logic [2:0] stepNext(input logic [2:0] s, input logic inv);
    if (inv) return (s == 3'd0) ? 3'd5 : s - 3'd1;
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  // Returns {a, b, c}; hiOn gates the PWM'd high-side phase of the step.
  function automatic logic [5:0] stepCodes(input logic [2:0] s, input logic hiOn);
    logic [1:0] hi;
    hi = hiOn ? CODE_HIGH : CODE_OFF;
    case (s)
      3'd0:    return {hi, CODE_LOW, CODE_OFF};
      3'd1:    return {hi, CODE_OFF, CODE_LOW};
      3'd2:    return {CODE_OFF, hi, CODE_LOW};
      3'd3:    return {CODE_LOW, hi, CODE_OFF};
      3'd4:    return {CODE_LOW, CODE_OFF, hi};
      3'd5:    return {CODE_OFF, CODE_LOW, hi};
      default: return {CODE_OFF, CODE_OFF, CODE_OFF};
    endcase
  endfunction

endpackage

// File: rtl/motor3_six_step_seq_if.sv
// Control and gate-drive bundle of the six-step sequencer.
// No valid/ready handshake: start/forceStop/invRotate are levels, the four
// INC/DEC lines act on their 0->1 edge, and every output is a registered level.
interface motor3_six_step_seq_if;
  import motor3_pkg::*;

  logic                m3startI;
  logic                m3forceStopI;
  logic                m3invRotateI;
  logic                m3freqINCi;
  logic                m3freqDECi;
  logic                m3powerINCi;
  logic                m3powerDECi;
  logic [1:0]          aD1U2O;
  logic [1:0]          bD1U2O;
  logic [1:0]          cD1U2O;
  logic [9:0]          freqO;
  logic [3:0]          powerO;
  logic [2:0]          stepO;
  logic                runningO;
  motor3_state_e       stateDbgO;

  modport master (
    output m3startI, m3forceStopI, m3invRotateI,
           m3freqINCi, m3freqDECi, m3powerINCi, m3powerDECi,
    input  aD1U2O, bD1U2O, cD1U2O, freqO, powerO, stepO, runningO, stateDbgO
  );

  modport slave (
    input  m3startI, m3forceStopI, m3invRotateI,
           m3freqINCi, m3freqDECi, m3powerINCi, m3powerDECi,
    output aD1U2O, bD1U2O, cD1U2O, freqO, powerO, stepO, runningO, stateDbgO
  );

endinterface

// File: rtl/motor3_six_step_seq_updown_sat.sv
// Rising-edge-triggered up/down counter saturating in [MIN_V, MAX_V].
module motor3_updown_sat #(
  parameter int          W     = 4,
  parameter int unsigned MIN_V = 0,
  parameter int unsigned MAX_V = 15,
  parameter int unsigned RST_V = 0
) (
  input  logic         clkI,
  input  logic         rstI,
  input  logic         incI,
  input  logic         decI,
  output logic [W-1:0] valueO
);

  localparam logic [W-1:0] MIN_L = W'(MIN_V);
  localparam logic [W-1:0] MAX_L = W'(MAX_V);
  localparam logic [W-1:0] RST_L = W'(RST_V);

  logic incQ;
  logic decQ;
  logic incRise;
  logic decRise;

  assign incRise = incI & ~incQ;
  assign decRise = decI & ~decQ;

  // Coincident INC and DEC edges cancel.
  always_ff @(posedge clkI) begin
    if (rstI) begin
      incQ   <= 1'b0;
      decQ   <= 1'b0;
      valueO <= RST_L;
    end else begin
      incQ <= incI;
      decQ <= decI;
      if (incRise && !decRise && (valueO < MAX_L)) begin
        valueO <= valueO + W'(1);
      end else if (decRise && !incRise && (valueO > MIN_L)) begin
        valueO <= valueO - W'(1);
      end
    end
  end

endmodule

// File: rtl/motor3_six_step_seq.sv
// Six-step BLDC commutation sequencer: phase accumulator sets step rate,
// PWM chops the high side, and a dead window separates every step change.
module motor3_six_step_seq
  import motor3_pkg::*;
(
  input  logic                  clkI,
  input  logic                  rstI,
  motor3_six_step_seq_if.slave  m3
);

  motor3_state_e        state;
  motor3_state_e        stateNext;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W:0]       accSum;
  logic [ACC_W:0]       accWrap;
  logic                 stepReq;
  logic [2:0]           step;
  logic [3:0]           pwmCnt;
  logic                 pwmOn;
  logic [1:0]           zeroCnt;
  logic                 zeroDone;
  logic [FREQ_W-1:0]    freq;
  logic [POWER_W-1:0]   power;
  logic [5:0]           codes;
  logic                 runningN;

  motor3_updown_sat #(
    .W(FREQ_W), .MIN_V(FREQ_MIN), .MAX_V(FREQ_MAX), .RST_V(FREQ_RST)
  ) freqCtr (
    .clkI(clkI), .rstI(rstI),
    .incI(m3.m3freqINCi), .decI(m3.m3freqDECi),
    .valueO(freq)
  );

  motor3_updown_sat #(
    .W(POWER_W), .MIN_V(0), .MAX_V(POWER_MAX), .RST_V(0)
  ) powerCtr (
    .clkI(clkI), .rstI(rstI),
    .incI(m3.m3powerINCi), .decI(m3.m3powerDECi),
    .valueO(power)
  );

  assign accSum   = {1'b0, acc} + (ACC_W+1)'(freq);
  assign accWrap  = accSum - (ACC_W+1)'(STEP_THRESH);
  assign stepReq  = (accSum >= (ACC_W+1)'(STEP_THRESH));
  assign pwmOn    = (pwmCnt < power);
  // zeroCnt measures dwell in the current state; IDLE also honours it so a
  // restart can never put a phase from LOW to HIGH without the dead window.
  assign zeroDone = (zeroCnt == 2'(DEAD_CYC - 1));

  always_ff @(posedge clkI) begin
    if (rstI) state <= ST_IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE: begin
        if (m3.m3forceStopI)                  stateNext = ST_BRAKE;
        else if (m3.m3startI && zeroDone)     stateNext = ST_RUN;
      end
      ST_RUN: begin
        if (m3.m3forceStopI)                  stateNext = ST_DEAD;
        else if (!m3.m3startI)                stateNext = ST_IDLE;
        else if (stepReq)                     stateNext = ST_DEAD;
      end
      ST_DEAD: begin
        if (m3.m3forceStopI) begin
          if (zeroDone)                       stateNext = ST_BRAKE;
        end else if (!m3.m3startI)            stateNext = ST_IDLE;
        else if (zeroDone)                    stateNext = ST_RUN;
      end
      ST_BRAKE: begin
        if (!m3.m3forceStopI)                 stateNext = ST_IDLE;
      end
      default:                                stateNext = ST_IDLE;
    endcase
  end

  always_comb begin
    codes    = {CODE_OFF, CODE_OFF, CODE_OFF};
    runningN = 1'b0;
    case (state)
      ST_RUN: begin
        runningN = 1'b1;
        codes    = stepCodes(step, pwmOn);
      end
      ST_DEAD:  runningN = 1'b1;
      ST_BRAKE: codes    = {CODE_LOW, CODE_LOW, CODE_LOW};
      default:  ;
    endcase
  end

  // The step advances on leaving RUN so the dead window already carries it.
  always_ff @(posedge clkI) begin
    if (rstI) begin
      acc     <= '0;
      step    <= '0;
      pwmCnt  <= '0;
      zeroCnt <= '0;
    end else begin
      if (stateNext != state)  zeroCnt <= '0;
      else if (!zeroDone)      zeroCnt <= zeroCnt + 2'd1;

      if ((state == ST_IDLE) && (stateNext == ST_RUN)) begin
        acc    <= '0;
        step   <= '0;
        pwmCnt <= '0;
      end else if (state == ST_RUN) begin
        if (stepReq) begin
          acc  <= accWrap[ACC_W-1:0];
          step <= stepNext(step, m3.m3invRotateI);
        end else begin
          acc  <= accSum[ACC_W-1:0];
        end
        pwmCnt <= (pwmCnt == 4'(PWM_PERIOD - 1)) ? 4'd0 : pwmCnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clkI) begin
    if (rstI) begin
      m3.aD1U2O   <= CODE_OFF;
      m3.bD1U2O   <= CODE_OFF;
      m3.cD1U2O   <= CODE_OFF;
      m3.stepO    <= '0;
      m3.runningO <= 1'b0;
    end else begin
      {m3.aD1U2O, m3.bD1U2O, m3.cD1U2O} <= codes;
      m3.stepO    <= step;
      m3.runningO <= runningN;
    end
  end

  assign m3.freqO     = freq;
  assign m3.powerO    = power;
  assign m3.stateDbgO = state;

endmodule

// File: tb/tb_motor3_six_step_seq.sv
// Directed self-checking bench for the six-step sequencer.
`timescale 1ns/1ps
module tb_motor3_six_step_seq;
  import motor3_pkg::*;

  localparam int FQ_INC = 0;
  localparam int FQ_DEC = 1;
  localparam int PW_INC = 2;
  localparam int PW_DEC = 3;
  localparam logic [5:0] ALL_LOW = 6'b01_01_01;

  logic clkI = 1'b0;
  logic rstI = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;

  motor3_six_step_seq_if m3if();

  motor3_six_step_seq dut (
    .clkI(clkI),
    .rstI(rstI),
    .m3(m3if)
  );

  always #500 clkI = ~clkI;

  // ---------------- clock/reset helpers and driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clkI);
      #1;
    end
  endtask

  function automatic logic [5:0] gates();
    return {m3if.aD1U2O, m3if.bD1U2O, m3if.cD1U2O};
  endfunction

  // Expected {a,b,c} for a step with the high side fully on.
  function automatic logic [5:0] exp_gates(input logic [2:0] s);
    case (s)
      3'd0:    return 6'b10_01_00;
      3'd1:    return 6'b10_00_01;
      3'd2:    return 6'b00_10_01;
      3'd3:    return 6'b01_10_00;
      3'd4:    return 6'b01_00_10;
      3'd5:    return 6'b00_01_10;
      default: return 6'b00_00_00;
    endcase
  endfunction

  task automatic set_sel(input int sel, input logic v);
    case (sel)
      FQ_INC:  m3if.m3freqINCi  = v;
      FQ_DEC:  m3if.m3freqDECi  = v;
      PW_INC:  m3if.m3powerINCi = v;
      PW_DEC:  m3if.m3powerDECi = v;
      default: ;
    endcase
  endtask

  task automatic pulse(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      set_sel(sel, 1'b1);
      tick(1);
      set_sel(sel, 1'b0);
      tick(1);
    end
  endtask

  task automatic wait_nonzero(input int limit, input string tag);
    int k;
    k = 0;
    while (k < limit && gates() == 6'd0) begin
      tick(1);
      k++;
    end
    checks++;
    if (gates() == 6'd0) begin
      failures++;
      $display("FAIL %s_timeout gates stayed 0 for %0d cycles", tag, limit);
    end
  endtask

  task automatic wait_zero(input int limit, input string tag);
    int k;
    k = 0;
    while (k < limit && gates() != 6'd0) begin
      tick(1);
      k++;
    end
    checks++;
    if (gates() != 6'd0) begin
      failures++;
      $display("FAIL %s_timeout gates never 0 within %0d cycles", tag, limit);
    end
  endtask

  // ---------------- phase-transition monitor ----------------
  logic [1:0] last_nz [3] = '{default: 2'd0};
  int         zero_run [3] = '{default: 100};

  always @(negedge clkI) begin
    logic [1:0] cur [3];
    if (mon_en) begin
      cur[0] = m3if.aD1U2O;
      cur[1] = m3if.bD1U2O;
      cur[2] = m3if.cD1U2O;
      for (int p = 0; p < 3; p++) begin
        if (cur[p] == CODE_OFF) begin
          if (zero_run[p] < 100) zero_run[p]++;
        end else begin
          if (last_nz[p] != CODE_OFF && last_nz[p] != cur[p]) begin
            checks++;
            if (zero_run[p] < int'(DEAD_CYC)) begin
              failures++;
              $display("FAIL phase_gap phase=%0d %0d->%0d after %0d zero cycles, need >= %0d",
                       p, last_nz[p], cur[p], zero_run[p], DEAD_CYC);
            end
          end
          last_nz[p]  = cur[p];
          zero_run[p] = 0;
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rstI = 1'b1;
    m3if.m3startI = 0; m3if.m3forceStopI = 0; m3if.m3invRotateI = 0;
    m3if.m3freqINCi = 0; m3if.m3freqDECi = 0; m3if.m3powerINCi = 0; m3if.m3powerDECi = 0;
    tick(3);
    checks++; if (gates() !== 6'd0) begin failures++; $display("FAIL reset_gates got=%b exp=000000", gates()); end
    checks++; if (m3if.freqO !== 10'd100) begin failures++; $display("FAIL reset_freq got=%0d exp=100", m3if.freqO); end
    checks++; if (m3if.powerO !== 4'd0) begin failures++; $display("FAIL reset_power got=%0d exp=0", m3if.powerO); end
    checks++; if (m3if.stepO !== 3'd0) begin failures++; $display("FAIL reset_step got=%0d exp=0", m3if.stepO); end
    checks++; if (m3if.runningO !== 1'b0) begin failures++; $display("FAIL reset_running got=%0d exp=0", m3if.runningO); end
    checks++; if (m3if.stateDbgO !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", m3if.stateDbgO, ST_IDLE); end
    rstI = 1'b0;
    tick(2);
    mon_en = 1'b1;
  endtask

  task automatic test_start_first_step();
    int n;
    int z;
    pulse(PW_INC, 16);
    checks++; if (m3if.powerO !== 4'd15) begin failures++; $display("FAIL power_sat_hi got=%0d exp=15", m3if.powerO); end
    m3if.m3startI = 1'b1;
    wait_nonzero(20, "start");
    checks++; if (gates() !== 6'b10_01_00) begin failures++; $display("FAIL step0_gates got=%b exp=100100", gates()); end
    checks++; if (m3if.stepO !== 3'd0) begin failures++; $display("FAIL step0_step got=%0d exp=0", m3if.stepO); end
    checks++; if (m3if.runningO !== 1'b1) begin failures++; $display("FAIL step0_running got=%0d exp=1", m3if.runningO); end
    n = 1;
    while (n < 3000) begin
      tick(1);
      if (gates() == 6'd0) break;
      n++;
    end
    checks++; if (n != 1667) begin failures++; $display("FAIL first_step_len got=%0d exp=1667", n); end
    z = 0;
    while (z < 10 && gates() == 6'd0) begin
      z++;
      tick(1);
    end
    checks++; if (z != 2) begin failures++; $display("FAIL first_dead_len got=%0d exp=2", z); end
    checks++; if (gates() !== 6'b10_00_01) begin failures++; $display("FAIL step1_gates got=%b exp=100001", gates()); end
    checks++; if (m3if.stepO !== 3'd1) begin failures++; $display("FAIL step1_step got=%0d exp=1", m3if.stepO); end
  endtask

  task automatic test_pwm();
    int hi;
    int lo;
    // Still inside step 1: phase A is high side, phase C is low side.
    pulse(PW_DEC, 10);
    checks++; if (m3if.powerO !== 4'd5) begin failures++; $display("FAIL power_5 got=%0d exp=5", m3if.powerO); end
    tick(3);
    hi = 0; lo = 0;
    for (int i = 0; i < 30; i++) begin
      if (m3if.aD1U2O == CODE_HIGH) hi++;
      if (m3if.cD1U2O == CODE_LOW) lo++;
      tick(1);
    end
    checks++; if (hi != 10) begin failures++; $display("FAIL pwm5_high got=%0d exp=10", hi); end
    checks++; if (lo != 30) begin failures++; $display("FAIL pwm5_low got=%0d exp=30", lo); end

    pulse(PW_DEC, 6);
    checks++; if (m3if.powerO !== 4'd0) begin failures++; $display("FAIL power_sat_lo got=%0d exp=0", m3if.powerO); end
    tick(3);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (m3if.aD1U2O == CODE_HIGH) hi++;
      tick(1);
    end
    checks++; if (hi != 0) begin failures++; $display("FAIL pwm0_high got=%0d exp=0", hi); end

    pulse(PW_INC, 15);
    tick(3);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      if (m3if.aD1U2O == CODE_HIGH) hi++;
      tick(1);
    end
    checks++; if (hi != 30) begin failures++; $display("FAIL pwm15_high got=%0d exp=30", hi); end

    m3if.m3startI = 1'b0;
    tick(3);
    checks++; if (gates() !== 6'd0) begin failures++; $display("FAIL stop_gates got=%b exp=000000", gates()); end
    checks++; if (m3if.runningO !== 1'b0) begin failures++; $display("FAIL stop_running got=%0d exp=0", m3if.runningO); end
  endtask

  task automatic test_freq_sat();
    pulse(FQ_INC, 900);
    checks++; if (m3if.freqO !== 10'd1000) begin failures++; $display("FAIL freq_900_inc got=%0d exp=1000", m3if.freqO); end
    pulse(FQ_INC, 1);
    checks++; if (m3if.freqO !== 10'd1000) begin failures++; $display("FAIL freq_sat_hi got=%0d exp=1000", m3if.freqO); end
    m3if.m3freqINCi = 1'b1; m3if.m3freqDECi = 1'b1;
    tick(1);
    m3if.m3freqINCi = 1'b0; m3if.m3freqDECi = 1'b0;
    tick(1);
    checks++; if (m3if.freqO !== 10'd1000) begin failures++; $display("FAIL freq_both_hi got=%0d exp=1000", m3if.freqO); end
    pulse(FQ_DEC, 999);
    checks++; if (m3if.freqO !== 10'd1) begin failures++; $display("FAIL freq_down_to_1 got=%0d exp=1", m3if.freqO); end
    pulse(FQ_DEC, 100);
    checks++; if (m3if.freqO !== 10'd1) begin failures++; $display("FAIL freq_sat_lo got=%0d exp=1", m3if.freqO); end
    pulse(FQ_INC, 4);
    checks++; if (m3if.freqO !== 10'd5) begin failures++; $display("FAIL freq_inc4 got=%0d exp=5", m3if.freqO); end
    m3if.m3freqINCi = 1'b1; m3if.m3freqDECi = 1'b1;
    tick(1);
    m3if.m3freqINCi = 1'b0; m3if.m3freqDECi = 1'b0;
    tick(1);
    checks++; if (m3if.freqO !== 10'd5) begin failures++; $display("FAIL freq_both_mid got=%0d exp=5", m3if.freqO); end
    m3if.m3powerINCi = 1'b1; m3if.m3powerDECi = 1'b1;
    tick(1);
    m3if.m3powerINCi = 1'b0; m3if.m3powerDECi = 1'b0;
    tick(1);
    checks++; if (m3if.powerO !== 4'd15) begin failures++; $display("FAIL power_both got=%0d exp=15", m3if.powerO); end
    pulse(FQ_INC, 995);
    checks++; if (m3if.freqO !== 10'd1000) begin failures++; $display("FAIL freq_restore got=%0d exp=1000", m3if.freqO); end
  endtask

  task automatic test_inv_rotate();
    logic [2:0] exp_q [$];
    logic [2:0] e;
    exp_q = '{3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd1};
    m3if.m3invRotateI = 1'b1;
    m3if.m3startI = 1'b1;
    for (int seg = 0; seg < 10; seg++) begin
      wait_nonzero((seg == 0) ? 20 : 10, "rot_seg");
      e = exp_q.pop_front();
      checks++; if (m3if.stepO !== e) begin failures++; $display("FAIL rot_step seg=%0d got=%0d exp=%0d", seg, m3if.stepO, e); end
      checks++; if (gates() !== exp_gates(e)) begin failures++; $display("FAIL rot_gates seg=%0d got=%b exp=%b", seg, gates(), exp_gates(e)); end
      if (seg == 6) begin
        tick(30);
        m3if.m3invRotateI = 1'b0;
      end else if (seg == 8) begin
        tick(30);
        m3if.m3invRotateI = 1'b1;
      end
      if (seg < 9) wait_zero(400, "rot_dead");
    end
    m3if.m3startI = 1'b0;
    m3if.m3invRotateI = 1'b0;
    tick(4);
  endtask

  task automatic test_force_stop();
    int n;
    int z;
    int saw_run;
    m3if.m3startI = 1'b1;
    wait_nonzero(20, "fs_start");
    tick(5);
    m3if.m3forceStopI = 1'b1;
    n = 0;
    while (n < 5 && gates() != 6'd0) begin
      tick(1);
      n++;
    end
    z = 0;
    while (z < 10 && gates() == 6'd0) begin
      tick(1);
      z++;
    end
    checks++; if (z != 2) begin failures++; $display("FAIL fs_dead_len got=%0d exp=2", z); end
    checks++; if (gates() !== ALL_LOW) begin failures++; $display("FAIL fs_brake_gates got=%b exp=%b", gates(), ALL_LOW); end
    checks++; if (m3if.stateDbgO !== ST_BRAKE) begin failures++; $display("FAIL fs_brake_state got=%0d exp=%0d", m3if.stateDbgO, ST_BRAKE); end
    tick(5);
    checks++; if (gates() !== ALL_LOW) begin failures++; $display("FAIL fs_brake_hold got=%b exp=%b", gates(), ALL_LOW); end
    m3if.m3startI = 1'b0;
    tick(2);
    m3if.m3forceStopI = 1'b0;
    tick(3);
    checks++; if (gates() !== 6'd0) begin failures++; $display("FAIL fs_release_gates got=%b exp=000000", gates()); end
    checks++; if (m3if.stateDbgO !== ST_IDLE) begin failures++; $display("FAIL fs_release_state got=%0d exp=%0d", m3if.stateDbgO, ST_IDLE); end

    m3if.m3forceStopI = 1'b1;
    m3if.m3startI = 1'b1;
    saw_run = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (m3if.runningO === 1'b1 || m3if.aD1U2O === CODE_HIGH ||
          m3if.bD1U2O === CODE_HIGH || m3if.cD1U2O === CODE_HIGH) saw_run++;
    end
    checks++; if (saw_run != 0) begin failures++; $display("FAIL fs_idle_never_run got=%0d run cycles exp=0", saw_run); end
    checks++; if (gates() !== ALL_LOW) begin failures++; $display("FAIL fs_idle_brake got=%b exp=%b", gates(), ALL_LOW); end
    m3if.m3startI = 1'b0;
    m3if.m3forceStopI = 1'b0;
    tick(4);
  endtask

  task automatic test_reset_mid_run();
    m3if.m3startI = 1'b1;
    wait_nonzero(20, "rst_start");
    tick(10);
    rstI = 1'b1;
    m3if.m3startI = 1'b0;
    tick(1);
    checks++; if (gates() !== 6'd0) begin failures++; $display("FAIL rst_run_gates got=%b exp=000000", gates()); end
    checks++; if (m3if.freqO !== 10'd100) begin failures++; $display("FAIL rst_run_freq got=%0d exp=100", m3if.freqO); end
    checks++; if (m3if.powerO !== 4'd0) begin failures++; $display("FAIL rst_run_power got=%0d exp=0", m3if.powerO); end
    checks++; if (m3if.runningO !== 1'b0) begin failures++; $display("FAIL rst_run_running got=%0d exp=0", m3if.runningO); end
    checks++; if (m3if.stepO !== 3'd0) begin failures++; $display("FAIL rst_run_step got=%0d exp=0", m3if.stepO); end
    rstI = 1'b0;
    tick(3);
    checks++; if (gates() !== 6'd0) begin failures++; $display("FAIL rst_after_gates got=%b exp=000000", gates()); end
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start_first_step();
    test_pwm();
    test_freq_sat();
    test_inv_rotate();
    test_force_stop();
    test_reset_mid_run();
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motor3_six_step_seq.md
MOTOR3_SIX_STEP_SEQ -- requirements
Module: motor3_six_step_seq

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports, one per line (name  direction  width  meaning):
- clkI  in  1  1 MHz clock.
- rstI  in  1  synchronous active-high reset.
- m3startI  in  1  level: run while high.
- m3forceStopI  in  1  level: brake request; overrides start.
- m3invRotateI  in  1  reverse step order.
- m3freqINCi / m3freqDECi  in  1 each  electrical-frequency +1 / -1, on rising edge.
- m3powerINCi / m3powerDECi  in  1 each  duty +1 / -1, on rising edge.
- aD1U2O / bD1U2O / cD1U2O  out  2 each  per-phase gate code to the half-bridge drivers: 0 = both off, 1 = low side on, 2 = high side on.
- freqO  out  10  current frequency in Hz.
- powerO  out  4  current duty level.
- stepO  out  3  commutation step, 0..5.
- runningO  out  1  high in RUN/DEAD state.

Function
REQ-003 SHALL implement FSM states IDLE, RUN, DEAD, BRAKE.
REQ-004 Transitions:
- IDLE -> RUN when m3startI=1 and m3forceStopI=0; this loads step 0 and clears the accumulator.
- RUN -> DEAD on a step advance or on forceStop.
- DEAD -> RUN (new step) after DEAD_CYC=2 cycles; DEAD -> BRAKE instead if forceStop is pending.
- RUN/DEAD -> IDLE when m3startI=0 (immediate, no dead window).
- BRAKE -> IDLE when m3forceStopI=0.
REQ-005 m3forceStopI SHALL have priority over m3startI in every state.
REQ-006 Step timing: 20-bit accumulator.
- Add freq each cycle in RUN.
- When acc+freq >= 166667, load acc+freq-166667 and request a step advance.
- Gives 6*freq steps per second.
- The accumulator holds its value in DEAD.
REQ-007 Step direction: advance = +1 mod 6 if m3invRotateI=0, else -1 mod 6 (0 wraps to 5). m3invRotateI is sampled at each advance only.
REQ-008 Step table (high phase / low phase, third phase 0): 0 A/B, 1 A/C, 2 B/C, 3 B/A, 4 C/A, 5 C/B.
REQ-009 PWM counter:
- Free-running 0..14 (period 15) in RUN.
- The high phase outputs 2 when counter < power, else 0.
- The low phase outputs 1 continuously.
- power=0 gives high side never on; power=15 gives high side always on.
REQ-010 DEAD and IDLE: all three outputs 0. BRAKE: all three outputs 1.
REQ-011 Inc/dec handling:
- Each input is registered once and acts on rising edge (0->1) only.
- freq saturates in 1..1000; power saturates in 0..15.
- Simultaneous INC and DEC rising edges on the same quantity produce no change.
- New values take effect on the next accumulator/PWM compare.
REQ-012 All outputs SHALL be registered; latency from the state/step change to the output code is 1 cycle.
REQ-013 No phase SHALL ever move 2->1 or 1->2 without at least 2 cycles at 0 in between.

Reset
REQ-014 While rstI=1 at a clock edge, SHALL load:
- state = IDLE; acc = 0; step = 0; PWM counter = 0.
- freq = 100; power = 0.
- all gate codes = 0; runningO = 0.
- edge-detect registers = 0.
REQ-015 Reset asserted mid-RUN SHALL drive all gate codes to 0 on the next output update, with no dead window required.

Structure
REQ-016 Shared package motor3_pkg SHALL hold:
- CODE_OFF/CODE_LOW/CODE_HIGH (0/1/2).
- STEP_THRESH = 166667, DEAD_CYC = 2, PWM_PERIOD = 15.
- FREQ_MIN = 1, FREQ_MAX = 1000, FREQ_RST = 100, POWER_MAX = 15.
- The FSM state enum.
REQ-017 One sub-module SHALL be used: motor3_updown_sat (rising-edge detect of INC/DEC plus saturating counter, parameterised width/min/max/reset value), instantiated twice (freq, power).

Verification
REQ-018 Reset, then start=1, power=15 -> step 0: aD1U2O=2, bD1U2O=1, cD1U2O=0. First advance ~1667 cycles later, preceded by 2 cycles of all-0, then step 1 (a=2, c=1).
REQ-019 900 freqINC pulses, then one more -> freqO=1000, saturated. 100 freqDEC from 1 -> freqO=1. INC+DEC same cycle -> unchanged.
REQ-020 power=5 in RUN -> high phase code 2 for exactly 5 of every 15 cycles. power=0 -> never 2. power=15 -> always 2 within a step.
REQ-021 invRotate=1 from step 0 -> sequence 0,5,4,3,2,1,0. Toggling invRotate mid-step alters only the next advance.
REQ-022 forceStop=1 during RUN -> 2 cycles of all-0, then all codes 1 (BRAKE). forceStop=0 -> IDLE, all 0. forceStop=1 with start=1 from IDLE -> BRAKE, never RUN.
REQ-023 Assertion over all tests: no phase transitions directly between 1 and 2. rstI mid-RUN -> all codes 0, freqO=100, powerO=0.
